// File: rtl/uart_rx_ctrl.sv
// UART receive controller: bus registers, byte FIFO and level irq; idle timeout only with UART_RX_TIMEOUT_EN.
// Reads answer one cycle after req; no backpressure, a byte arriving at a full FIFO is dropped and flags overrun.
module uart_rx_ctrl #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RESET = 16'd868
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq,
  output logic [15:0] bit_period,
  output logic        rx_nrst,
  input  logic [7:0]  rx_data,
  input  logic        rx_busy,
  input  logic        rx_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d, timeout_q, timeout_d;
  logic [15:0]   baud_q, baud_d;
  logic          enable_q, enable_d;
  logic [2:0]    ien_q, ien_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, irq_q, irq_d, rx_nrst_q;

  logic rd_req, wr_req, flush, ovr_clr, pop, push, drop;
  logic not_empty, full, not_empty_d, full_d;
  logic [31:0] status_w;
  logic unused_wdata;

  assign unused_wdata = ^wdata[31:16];

  assign rd_req    = req & ~we;
  assign wr_req    = req & we;
  assign flush     = wr_req & (addr == 2'd3) & wdata[4];
  assign ovr_clr   = wr_req & (addr == 2'd1) & wdata[2];
  assign not_empty = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign pop       = rd_req & (addr == 2'd0) & not_empty & ~flush;
  // a coinciding pop frees the slot, so a full FIFO can still accept the byte
  assign push      = rx_done & enable_q & (~full | pop) & ~flush;
  assign drop      = rx_done & enable_q & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    baud_d   = baud_q;
    enable_d = enable_q;
    ien_d    = ien_q;
    if (wr_req && addr == 2'd2) baud_d = wdata[15:0];
    if (wr_req && addr == 2'd3) begin
      enable_d = wdata[0];
      ien_d    = wdata[3:1];
    end
  end

  assign overrun_d = (overrun_q & ~ovr_clr) | drop;

`ifdef UART_RX_TIMEOUT_EN
  logic [17:0] tcnt_q, tcnt_d;
  logic [17:0] tlimit;

  assign tlimit = {baud_q, 2'b00};

  always_comb begin
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    if (push || pop || flush || rx_busy) begin
      tcnt_d = '0;
    end else if (not_empty && !timeout_q && tcnt_q != '1) begin
      tcnt_d = tcnt_q + 18'd1;
      if (baud_q != '0 && tcnt_d >= tlimit) timeout_d = 1'b1;
    end
    if (pop || flush) timeout_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) tcnt_q <= '0;
    else       tcnt_q <= tcnt_d;
  end
`else
  assign timeout_d = 1'b0;
`endif

  assign irq_d = (ien_q[0] & not_empty) | (ien_q[1] & timeout_q) | (ien_q[2] & overrun_q);

  // STATUS shows the state this edge produces; DATA returns the head before the pop
  assign not_empty_d = (count_d != '0);
  assign full_d      = (count_d == FULL_CNT);
  assign status_w    = {16'h0, 8'(count_d), 3'b000, timeout_d, rx_busy, overrun_d, full_d, not_empty_d};

  always_comb begin
    rdata_d = rdata_q;
    if (rd_req) begin
      case (addr)
        2'd0:    rdata_d = pop ? {24'h0, mem_q[rd_ptr_q]} : 32'h0;
        2'd1:    rdata_d = status_w;
        2'd2:    rdata_d = {16'h0, baud_q};
        default: rdata_d = {28'h0, ien_q, enable_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      baud_q    <= BAUD_RESET;
      enable_q  <= 1'b1;
      ien_q     <= 3'b000;
      rdata_q   <= 32'h0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
      rx_nrst_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      baud_q    <= baud_d;
      enable_q  <= enable_d;
      ien_q     <= ien_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rd_req;
      irq_q     <= irq_d;
      rx_nrst_q <= enable_q;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst && push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign irq        = irq_q;
  assign bit_period = baud_q;
  assign rx_nrst    = rx_nrst_q;
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Register-mapped controller for the UART receive path. It configures the receiver's bit period and enables or disables it, and captures each completed byte into a receive FIFO. It also tracks overrun and idle-timeout conditions and raises a level interrupt to the core. It sits between the core's peripheral bus and a single UART receiver instance.

## Interface
- FIFO_DEPTH, 8: receive FIFO entries; power of two, ≥2.
- BAUD_RESET, 16'd868: reset value of the BAUD register (clocks per bit).

- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- req  in  1  bus access strobe, one cycle per access.
- we  in  1  1 = write, 0 = read.
- addr  in  2  word register index.
- wdata  in  32  write data.
- rdata  out  32  read data, valid when rvalid=1.
- rvalid  out  1  one-cycle pulse, one cycle after a read req.
- irq  out  1  registered level interrupt.
- bit_period  out  16  receiver clocks per bit; equals BAUD.
- rx_nrst  out  1  registered receiver reset, active-low.
- rx_data  in  8  received byte from the receiver.
- rx_busy  in  1  receiver is mid-frame.
- rx_done  in  1  one-cycle pulse; rx_data is valid in that cycle.

## Operation
- Register map:
  - 0 DATA (R): pop FIFO head into rdata[7:0], upper bits 0. If the FIFO is empty, rdata=0 and there is no pop. Writes are ignored.
  - 1 STATUS:
    - Read: [0] not_empty, [1] full, [2] overrun, [3] rx_busy, [4] timeout, [15:8] count, other bits 0.
    - Write: 1 to bit 2 clears overrun; all other bits are ignored.
  - 2 BAUD (RW): bits [15:0]. A write drives bit_period the next cycle. A write while rx_busy=1 is accepted; the frame in flight is undefined.
  - 3 CTRL (RW):
    - [0] enable, reset 1.
    - [1] irq_en_data, [2] irq_en_timeout, [3] irq_en_overrun; reset 0.
    - [4] flush: write-only, self-clearing, reads 0.
- rx_nrst <= enable. While enable=0, rx_done is ignored and nothing is pushed.
- Push: on a clock edge with rx_done=1, enable=1 and the FIFO not full, rx_data is written at the tail.
- Overrun: rx_done=1 with the FIFO full and no pop in the same cycle drops the byte and sets overrun (sticky).
- Push and pop in the same cycle: both happen and count is unchanged. A push when full succeeds if a pop coincides.
- Flush: empties the FIFO (pointers and count to 0) and clears timeout. Overrun is unaffected. Flush wins over a coinciding push or pop; a coinciding DATA read returns 0.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. count is log2(FIFO_DEPTH)+1 bits wide, zero-extended into STATUS[15:8].
- irq <= (irq_en_data & not_empty) | (irq_en_timeout & timeout) | (irq_en_overrun & overrun).

## Timing
- Reset values: rdata=0, rvalid=0, irq=0, rx_nrst=0, bit_period=BAUD_RESET, FIFO empty, overrun=0, timeout=0.
- Reads: rdata and rvalid are registered, so the latency is 1 cycle. A DATA read returns the head before the pop.
- Writes take effect at the edge of the request cycle.
- Push latency: a byte with rx_done in cycle N is visible in STATUS and readable from cycle N+1.
- STATUS reflects state after the request-cycle edge updates, except that the DATA value returned is the pre-pop head.
- irq lags the underlying flags by one cycle.
- rx_nrst goes high the first cycle after reset releases, and goes low one cycle after a CTRL write with enable=0.
- Reset asserted mid-operation returns everything to reset values at the next edge; buffered bytes are lost.

## Configuration
- UART_RX_TIMEOUT_EN: when defined, the idle-timeout logic is compiled in.
  - An 18-bit counter increments each cycle while not_empty=1 and rx_busy=0.
  - The counter clears on push, pop, flush, or rx_busy=1.
  - When the counter reaches {bit_period,2'b00} (4 bit periods), timeout sets.
  - Timeout clears on pop or flush. bit_period=0 disables timeout.
- When not defined: STATUS[4] reads 0, timeout never sets, and irq_en_timeout has no effect. The CTRL[2] bit still stores its written value.

## Test plan
- Reset, then read each register: DATA=0, STATUS=0, BAUD=868, CTRL=1. bit_period=868, irq=0, and rx_nrst=1 from the cycle after reset release.
- Pulse rx_done with 0x41 and then 0x42, then read DATA twice: returns 0x41 then 0x42, and STATUS count goes 2 → 1 → 0.
- FIFO_DEPTH=8: push 9 bytes 0x00..0x08 with no reads.
  - STATUS expected: full=1, overrun=1, count=8. Reads return 0x00..0x07.
  - Writing STATUS=0x4 clears overrun.
- FIFO full, with rx_done=0x55 in the same cycle as a DATA read: rdata=old head, count stays 8, overrun stays 0, and 0x55 is read last.
- CTRL=0x3 with one byte pushed: irq=1 two cycles after rx_done. A CTRL write with flush=1 and enable=1 clears count, and irq drops two cycles after the flush write.
- With UART_RX_TIMEOUT_EN defined and BAUD=16: push one byte, hold rx_busy=0. timeout sets 64 cycles after the push, and a DATA read clears it.
